mmu_sequencer: RTL and testbench

Controller that sequences one 4x4 systolic matrix-multiply unit (MMU) per job. It collects a weight matrix W and a data matrix A over a valid/ready stream and preloads W into the array. It then streams A into the array with per-lane diagonal skew, captures the DEPTH accumulator rows the array produces, and returns C = A·W row by row over a second valid/ready stream. It sits between the host-side load/result buffers and the MMU datapath, and is the only driver of the MMU's control, data and weight inputs.

---
 rtl/mmu_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mmu_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mmu_sequencer
// Purpose  : Runs one job at a time on a DEPTH x DEPTH systolic matrix-multiply
//            unit. It collects W and A over a valid/ready stream, preloads W
//            with the last row first, streams A with diagonal skew, captures
//            the DEPTH result rows and returns C = A*W over a second stream.
// Ports    : clk, reset (async, active-low)
//            in_valid / in_ready / in_row       : W rows then A rows, lane 0 MSBs
//            mmu_control / mmu_data_arr /
//            mmu_wt_arr                         : drives into the MMU (registered)
//            mmu_acc_out                        : MMU result row
//            res_valid / res_ready / res_row /
//            res_last                           : C rows, res_last on final row
//            busy                               : high outside COLLECT
// Revision : 1.0 - initial release
// ============================================================================
module mmu_sequencer #(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int RES_LAT   = 8   // must be >= 2*DEPTH-2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIT_WIDTH*DEPTH-1:0]     in_row,
  output logic                           mmu_control,
  output logic [BIT_WIDTH*DEPTH-1:0]     mmu_data_arr,
  output logic [BIT_WIDTH*DEPTH-1:0]     mmu_wt_arr,
  input  logic [ACC_WIDTH*DEPTH-1:0]     mmu_acc_out,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ACC_WIDTH*DEPTH-1:0]     res_row,
  output logic                           res_last,
  output logic                           busy
);

  localparam int c_ROW_BITS = BIT_WIDTH * DEPTH;
  localparam int c_RES_BITS = ACC_WIDTH * DEPTH;
  localparam int c_BEAT_W   = $clog2(2 * DEPTH);
  localparam int c_CNT_W    = $clog2(RES_LAT + DEPTH + 1);
  localparam int c_ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] c_ST_COLLECT = 3'd0;
  localparam logic [2:0] c_ST_LOADW   = 3'd1;
  localparam logic [2:0] c_ST_FEED    = 3'd2;
  localparam logic [2:0] c_ST_DRAIN   = 3'd3;
  localparam logic [2:0] c_ST_OUT     = 3'd4;

  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST  = c_BEAT_W'(2 * DEPTH - 1);
  localparam logic [c_CNT_W-1:0]  c_LOAD_LAST  = c_CNT_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0]  c_FEED_LAST  = c_CNT_W'(2 * DEPTH - 2);
  // The cycle counter runs one cycle ahead of the registered MMU drives, so
  // the last capture (and the exit from DRAIN) is at RES_LAT+DEPTH here.
  localparam logic [c_CNT_W-1:0]  c_DRAIN_LAST = c_CNT_W'(RES_LAT + DEPTH);
  localparam logic [c_ROW_W-1:0]  c_ROW_LAST   = c_ROW_W'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [2:0]            r_state;
  logic [c_BEAT_W-1:0]   r_beat;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_ROW_W-1:0]    r_row;
  logic [c_ROW_BITS-1:0] r_w_rows  [DEPTH];
  logic [c_ROW_BITS-1:0] r_a_rows  [DEPTH];
  logic [c_RES_BITS-1:0] r_res_buf [DEPTH];

  logic                  r_mmu_control;
  logic [c_ROW_BITS-1:0] r_mmu_data;
  logic [c_ROW_BITS-1:0] r_mmu_wt;
  logic                  r_res_valid;
  logic [c_RES_BITS-1:0] r_res_row;
  logic                  r_res_last;

  // --------------------------------------------------------------------------
  // Combinational next values
  // --------------------------------------------------------------------------
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [2:0]            w_state_nxt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic [c_ROW_W-1:0]    w_row_nxt;
  logic [c_RES_BITS-1:0] w_buf_nxt [DEPTH];
  logic                  w_ctrl_nxt;
  logic [c_ROW_BITS-1:0] w_data_nxt;
  logic [c_ROW_BITS-1:0] w_wt_nxt;
  logic                  w_res_valid_nxt;
  logic [c_RES_BITS-1:0] w_res_row_nxt;
  logic                  w_res_last_nxt;

  assign in_ready   = (r_state == c_ST_COLLECT);
  assign busy       = (r_state != c_ST_COLLECT);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_res_valid & res_ready & (r_state == c_ST_OUT);

  assign mmu_control  = r_mmu_control;
  assign mmu_data_arr = r_mmu_data;
  assign mmu_wt_arr   = r_mmu_wt;
  assign res_valid    = r_res_valid;
  assign res_row      = r_res_row;
  assign res_last     = r_res_last;

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next state and sequencing counters
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_row_nxt   = '0;
    case (r_state)
      c_ST_COLLECT: begin
        if (w_in_fire && (r_beat == c_BEAT_LAST)) begin
          w_state_nxt = c_ST_LOADW;
        end
      end
      c_ST_LOADW: begin
        if (r_cnt == c_LOAD_LAST) begin
          w_state_nxt = c_ST_FEED;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      c_ST_FEED: begin
        // Counter keeps running into DRAIN so capture slots line up.
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_FEED_LAST) begin
          w_state_nxt = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (r_cnt == c_DRAIN_LAST) begin
          w_state_nxt = c_ST_OUT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      c_ST_OUT: begin
        w_row_nxt = r_row;
        if (w_out_fire) begin
          if (r_row == c_ROW_LAST) begin
            w_state_nxt = c_ST_COLLECT;
            w_row_nxt   = '0;
          end else begin
            w_row_nxt = r_row + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = c_ST_COLLECT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: next values of the registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_ctrl_nxt      = 1'b0;
    w_data_nxt      = '0;
    w_wt_nxt        = '0;
    w_res_valid_nxt = 1'b0;
    w_res_row_nxt   = '0;
    w_res_last_nxt  = 1'b0;

    // Result buffer including this cycle's capture, so a row captured on the
    // same edge that enters OUT is already visible on res_row.
    for (int r = 0; r < DEPTH; r++) begin
      w_buf_nxt[r] = r_res_buf[r];
      if (((r_state == c_ST_FEED) || (r_state == c_ST_DRAIN)) &&
          (r_cnt == c_CNT_W'(RES_LAT + 1 + r))) begin
        w_buf_nxt[r] = mmu_acc_out;
      end
    end

    case (r_state)
      c_ST_LOADW: begin
        w_ctrl_nxt = 1'b1;
        // Last W row enters first so row 0 ends up in the top PE row.
        for (int i = 0; i < DEPTH; i++) begin
          if (r_cnt == c_CNT_W'(DEPTH - 1 - i)) begin
            w_wt_nxt = r_w_rows[i];
          end
        end
      end
      c_ST_FEED: begin
        // Lane j carries A[c-j][j]: each lane is delayed by its index.
        for (int j = 0; j < DEPTH; j++) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt == c_CNT_W'(i + j)) begin
              w_data_nxt[(DEPTH-1-j)*BIT_WIDTH +: BIT_WIDTH] =
                r_a_rows[i][(DEPTH-1-j)*BIT_WIDTH +: BIT_WIDTH];
            end
          end
        end
      end
      default: begin
      end
    endcase

    if (w_state_nxt == c_ST_OUT) begin
      w_res_valid_nxt = 1'b1;
      w_res_last_nxt  = (w_row_nxt == c_ROW_LAST);
      for (int r = 0; r < DEPTH; r++) begin
        if (w_row_nxt == c_ROW_W'(r)) begin
          w_res_row_nxt = w_buf_nxt[r];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat        <= '0;
      r_cnt         <= '0;
      r_row         <= '0;
      r_mmu_control <= 1'b0;
      r_mmu_data    <= '0;
      r_mmu_wt      <= '0;
      r_res_valid   <= 1'b0;
      r_res_row     <= '0;
      r_res_last    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_w_rows[i]  <= '0;
        r_a_rows[i]  <= '0;
        r_res_buf[i] <= '0;
      end
    end else begin
      if (w_in_fire) begin
        r_beat <= (r_beat == c_BEAT_LAST) ? '0 : r_beat + 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (r_beat == c_BEAT_W'(i)) begin
            r_w_rows[i] <= in_row;
          end
          if (r_beat == c_BEAT_W'(DEPTH + i)) begin
            r_a_rows[i] <= in_row;
          end
        end
      end
      r_cnt <= w_cnt_nxt;
      r_row <= w_row_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_res_buf[i] <= w_buf_nxt[i];
      end
      r_mmu_control <= w_ctrl_nxt;
      r_mmu_data    <= w_data_nxt;
      r_mmu_wt      <= w_wt_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_res_row     <= w_res_row_nxt;
      r_res_last    <= w_res_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_sequencer
// Purpose  : Directed bench for mmu_sequencer with a behavioural systolic MMU
//            that rebuilds A from the skewed lanes and W from the preload,
//            and a scoreboard of expected C = A*W rows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_sequencer;

  localparam int D  = 4;
  localparam int BW = 8;
  localparam int AW = 32;
  localparam int RL = 8;
  localparam logic [AW*D-1:0] c_GARBAGE = {D{32'hDEAD_BEEF}};

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [BW*D-1:0]   in_row;
  logic              mmu_control;
  logic [BW*D-1:0]   mmu_data_arr;
  logic [BW*D-1:0]   mmu_wt_arr;
  logic [AW*D-1:0]   mmu_acc_out;
  logic              res_valid;
  logic              res_ready;
  logic [AW*D-1:0]   res_row;
  logic              res_last;
  logic              busy;

  mmu_sequencer #(.DEPTH(D), .BIT_WIDTH(BW), .ACC_WIDTH(AW), .RES_LAT(RL)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .mmu_control  (mmu_control),
    .mmu_data_arr (mmu_data_arr),
    .mmu_wt_arr   (mmu_wt_arr),
    .mmu_acc_out  (mmu_acc_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_row      (res_row),
    .res_last     (res_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [AW*D-1:0] obs, input logic [AW*D-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic give_up(input string tag);
    total++;
    bad++;
    $display("FAIL %s: timed out", tag);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Job matrices and scoreboard
  int unsigned Wm [D][D];
  int unsigned Am [D][D];

  typedef struct {
    logic [AW*D-1:0] row;
    logic            last;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [BW*D-1:0] beat_row(input int b);
    logic [BW*D-1:0] v;
    v = '0;
    for (int j = 0; j < D; j++) begin
      if (b < D) v[(D-1-j)*BW +: BW] = BW'(Wm[b][j]);
      else       v[(D-1-j)*BW +: BW] = BW'(Am[b-D][j]);
    end
    return v;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < D; r++) begin
      e.row = '0;
      for (int j = 0; j < D; j++) begin
        int unsigned s;
        s = 0;
        for (int k = 0; k < D; k++) s += Am[r][k] * Wm[k][j];
        e.row[(D-1-j)*AW +: AW] = s;
      end
      e.last = (r == D - 1);
      exp_q.push_back(e);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural MMU: records preload and skewed data, drives result rows at
  // FEED cycles RL..RL+D-1 and garbage at all other times.
  // --------------------------------------------------------------------------
  int unsigned wload [D][D];
  int unsigned arec  [D][D];
  int          fc = -1;
  int          pl = 0;
  bit          armed = 0;

  function automatic int unsigned dl(input logic [BW*D-1:0] v, input int j);
    return 32'(v[(D-1-j)*BW +: BW]);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      armed = 0; pl = 0; fc = -1;
      mmu_acc_out = c_GARBAGE;
    end else if (mmu_control) begin
      if (pl < D) for (int j = 0; j < D; j++) wload[pl][j] = dl(mmu_wt_arr, j);
      check("data_zero_in_loadw", mmu_data_arr, '0);
      pl++; armed = 1; fc = -1;
      mmu_acc_out = c_GARBAGE;
    end else if (armed) begin
      fc++;
      if (fc == 0) check("preload_cycles", pl, D);
      check("wt_zero_in_feed", mmu_wt_arr, '0);
      for (int j = 0; j < D; j++) begin
        int i;
        i = fc - j;
        if (i >= 0 && i < D) arec[i][j] = dl(mmu_data_arr, j);
        else check("skew_lane_zero", dl(mmu_data_arr, j), 0);
      end
      if (fc >= RL && fc < RL + D) begin
        int r;
        r = fc - RL;
        for (int j = 0; j < D; j++) begin
          int unsigned s;
          s = 0;
          for (int k = 0; k < D; k++) s += arec[r][k] * wload[D-1-k][j];
          mmu_acc_out[(D-1-j)*AW +: AW] = s;
        end
        if (fc == RL + D - 1) begin
          armed = 0; pl = 0;
        end
      end else begin
        mmu_acc_out = c_GARBAGE;
      end
    end else begin
      mmu_acc_out = c_GARBAGE;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  int last_acc  = 0;
  int first_acc = 0;
  int final_cyc = 0;

  task automatic send_job(input bit hold_valid);
    push_expected();
    for (int b = 0; b < 2 * D; b++) begin
      int n;
      in_row   = beat_row(b);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) give_up("in_ready_wait");
      @(posedge clk);
      @(negedge clk);
      if (b == 0) first_acc = cyc;
    end
    in_valid = hold_valid;
    last_acc = cyc;
  endtask

  task automatic collect(input int stall_row, input int stall_len, input bit chk_lat);
    int got, n, stall_left;
    bit seen;
    exp_t e;
    got = 0; n = 0; stall_left = stall_len; seen = 0;
    while (got < D && n < 300) begin
      res_ready = 1'b1;
      if (res_valid && got == stall_row && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end
      if (res_valid && !seen) begin
        seen = 1;
        if (chk_lat) check("first_res_latency", cyc - last_acc, 2 * D + RL + 1);
      end
      check("in_ready_low_while_busy", in_ready, 1'b0);
      if (res_valid && exp_q.size() > 0) begin
        if (res_ready) begin
          e = exp_q.pop_front();
          check("res_row", res_row, e.row);
          check("res_last", res_last, e.last);
          got++;
        end else begin
          check("hold_res_row", res_row, exp_q[0].row);
          check("hold_res_last", res_last, exp_q[0].last);
        end
      end
      @(negedge clk);
      n++;
    end
    if (got < D) give_up("result_wait");
    res_ready = 1'b1;
    final_cyc = cyc;
    check("in_ready_after_job", in_ready, 1'b1);
    check("busy_after_job", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_in_ready"}, in_ready, 1'b1);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_mmu_control"}, mmu_control, 1'b0);
    check({pfx, "_mmu_data_arr"}, mmu_data_arr, '0);
    check({pfx, "_mmu_wt_arr"}, mmu_wt_arr, '0);
    check({pfx, "_res_valid"}, res_valid, 1'b0);
    check({pfx, "_res_row"}, res_row, '0);
    check({pfx, "_res_last"}, res_last, 1'b0);
  endtask

  task automatic set_identity();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        Wm[i][j] = (i == j) ? 1 : 0;
        Am[i][j] = i * D + j + 1;
      end
  endtask

  task automatic set_uniform(input int unsigned a, input int unsigned w);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        Am[i][j] = a;
        Wm[i][j] = w;
      end
  endtask

  initial begin
    #300000;
    give_up("global_watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_row    = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    // Identity: results equal A rows, latency checked
    set_identity();
    send_job(1'b0);
    collect(-1, 0, 1'b1);

    // Uniform A=1, W=2: every lane 8
    set_uniform(1, 2);
    send_job(1'b0);
    collect(-1, 0, 1'b0);

    // Max operands: every lane 260100
    set_uniform(255, 255);
    send_job(1'b0);
    collect(-1, 0, 1'b0);

    // Backpressure: 5 stalled cycles at row 1
    Wm = '{'{1, 2, 0, 1}, '{0, 1, 3, 2}, '{2, 0, 1, 1}, '{1, 1, 1, 0}};
    Am = '{'{3, 1, 4, 1}, '{5, 9, 2, 6}, '{5, 3, 5, 8}, '{9, 7, 9, 3}};
    send_job(1'b0);
    collect(1, 5, 1'b0);

    // Reset during FEED cycle 3
    set_uniform(9, 4);
    send_job(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (fc != 3 && n < 100);
    if (n >= 100) give_up("feed_c3_wait");
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    check_reset_values("midreset_held");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    set_identity();
    send_job(1'b0);
    collect(-1, 0, 1'b1);

    // Back-to-back: in_valid held high across jobs
    Wm = '{'{2, 0, 1, 3}, '{1, 4, 0, 2}, '{0, 1, 5, 1}, '{3, 2, 1, 0}};
    Am = '{'{7, 0, 2, 1}, '{1, 1, 1, 1}, '{4, 3, 2, 9}, '{0, 6, 8, 5}};
    send_job(1'b1);
    set_uniform(7, 3);
    for (int j = 0; j < D; j++) Wm[1][j] = 32'(j + 1);
    in_row   = beat_row(0);
    in_valid = 1'b1;
    collect(-1, 0, 1'b0);
    send_job(1'b0);
    check("b2b_first_accept_cycle", first_acc - final_cyc, 1);
    collect(-1, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
